// File: rtl/sync_updown_mod_counter.sv
// Fully synchronous modulo-MODULUS up/down counter with clamped parallel load,
// wrap or saturate at the boundaries, combinational cascade tc and a wrap pulse.
module sync_updown_mod_counter #(
  parameter int              WIDTH    = 4,
  parameter longint unsigned MODULUS  = 16,
  parameter bit              SATURATE = 1'b0
) (
  input  logic             clk,
  input  logic             res,
  input  logic             en,
  input  logic             dir,
  input  logic             load,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic             wrapped
);

  // MODULUS can reach 2^32, so the legality check is done in 64 bits.
  if (WIDTH < 1 || WIDTH > 32) begin : g_bad_width
    $error("sync_updown_mod_counter: WIDTH must be in 1..32");
  end
  if (MODULUS < 2 || MODULUS > (64'd1 << WIDTH)) begin : g_bad_modulus
    $error("sync_updown_mod_counter: MODULUS must be in 2..2^WIDTH");
  end

  localparam logic [WIDTH-1:0] QMAX = WIDTH'(MODULUS - 64'd1);

  logic             at_max;
  logic             at_zero;
  logic [WIDTH-1:0] din_clamp;
  logic [WIDTH-1:0] q_nxt;
  logic             wrap_nxt;

  assign at_max    = (q == QMAX);
  assign at_zero   = (q == '0);
  assign din_clamp = (din > QMAX) ? QMAX : din;

  // Priority: load, then count, then hold; reset overrides in the register.
  always_comb begin
    q_nxt    = q;
    wrap_nxt = 1'b0;
    if (load) begin
      q_nxt = din_clamp;
    end else if (en) begin
      if (dir) begin
        if (!at_max) begin
          q_nxt = q + WIDTH'(1);
        end else if (!SATURATE) begin
          q_nxt    = '0;
          wrap_nxt = 1'b1;
        end
      end else begin
        if (!at_zero) begin
          q_nxt = q - WIDTH'(1);
        end else if (!SATURATE) begin
          q_nxt    = QMAX;
          wrap_nxt = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (res) begin
      q       <= '0;
      wrapped <= 1'b0;
    end else begin
      q       <= q_nxt;
      wrapped <= wrap_nxt;
    end
  end

  // Unregistered so a cascaded upper stage counts on the same edge.
  assign tc = ~res & en & ~load & ((dir & at_max) | (~dir & at_zero));

endmodule
